// File: rtl/pe_param.sv
// Parametrised systolic PE: operand FIFOs, 3-stage MAC, forwarding and a
// valid/ready result port with optional saturating accumulation.

module pe_param_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         we,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          wr;

    always_comb begin
        // a pop in the same cycle frees a slot, so a write while full is taken
        wr     = we & (~full_q | pop);
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        cnt_d  = cnt_q + (PW+1)'(wr) - (PW+1)'(pop);
        full_d = (cnt_d == (PW+1)'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign dout  = mem_q[rptr_q];
    assign empty = (cnt_q == '0);
    assign full  = full_q;
endmodule

module pe_param #(
    parameter int DW     = 16,
    parameter int AW     = 40,
    parameter int FDEPTH = 4,
    parameter int SAT_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a_in,
    input  logic          a_we,
    input  logic [DW-1:0] b_in,
    input  logic          b_we,
    output logic          aff,
    output logic          bff,
    input  logic          sgn,
    input  logic          start,
    input  logic [7:0]    max_cntr,
    input  logic          hold,
    output logic [DW-1:0] a_out,
    output logic          a_vld,
    output logic [DW-1:0] b_out,
    output logic          b_vld,
    output logic          start_next,
    output logic [AW-1:0] s_out,
    output logic          s_sat,
    output logic          s_vld,
    input  logic          s_rdy
);
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    logic [DW-1:0]   a_dout, b_dout;
    logic            a_empty, b_empty, stall, pop;

    logic [DW-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic            s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [2*DW-1:0] prod_q, prod_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [8:0]      cnt_q, cnt_d, len_q, len_d;
    logic            sgn_q, sgn_d, sat_q, sat_d;
    logic [DW-1:0]   a_out_q, a_out_d, b_out_q, b_out_d;
    logic            a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic            start_next_q, start_next_d;
    logic [AW-1:0]   s_out_q, s_out_d;
    logic            s_sat_q, s_sat_d, s_vld_q, s_vld_d;

    logic [2*DW-1:0] a_ext, b_ext, prod_full;
    logic [AW:0]     prod_x, sum;
    logic [AW-1:0]   acc_base, sum_c;
    logic [8:0]      cnt_base;
    logic            sat_base, done, ovf;

    assign stall = hold | (s_vld_q & ~s_rdy);
    // no pop on a start cycle: that pair would be thrown away with the S1 valid
    assign pop   = ~a_empty & ~b_empty & ~stall & ~start;

    pe_param_fifo #(.W(DW), .DEPTH(FDEPTH)) u_afifo (
        .clk(clk), .rst(rst), .din(a_in), .we(a_we), .pop(pop),
        .dout(a_dout), .empty(a_empty), .full(aff)
    );
    pe_param_fifo #(.W(DW), .DEPTH(FDEPTH)) u_bfifo (
        .clk(clk), .rst(rst), .din(b_in), .we(b_we), .pop(pop),
        .dout(b_dout), .empty(b_empty), .full(bff)
    );

    always_comb begin
        a_ext     = {{DW{sgn_q & s1_a_q[DW-1]}}, s1_a_q};
        b_ext     = {{DW{sgn_q & s1_b_q[DW-1]}}, s1_b_q};
        prod_full = a_ext * b_ext;
        prod_x    = {{(AW+1-2*DW){sgn_q & prod_q[2*DW-1]}}, prod_q};

        // completion and a fresh first term can share a cycle
        done     = (cnt_q != '0) && (cnt_q == len_q);
        acc_base = done ? '0 : acc_q;
        cnt_base = done ? '0 : cnt_q;
        sat_base = done ? 1'b0 : sat_q;

        sum = {sgn_q & acc_base[AW-1], acc_base} + prod_x;
        ovf = sgn_q ? (sum[AW] ^ sum[AW-1]) : sum[AW];
        if ((SAT_EN != 0) && ovf)
            sum_c = sgn_q ? (sum[AW] ? ACC_MIN : ACC_MAX) : '1;
        else
            sum_c = sum[AW-1:0];

        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_v_d       = s1_v_q;
        s2_v_d       = s2_v_q;
        prod_d       = prod_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        sgn_d        = sgn_q;
        sat_d        = sat_q;
        a_out_d      = a_out_q;
        b_out_d      = b_out_q;
        a_vld_d      = pop;
        b_vld_d      = pop;
        start_next_d = start;
        s_out_d      = s_out_q;
        s_sat_d      = s_sat_q;
        s_vld_d      = s_vld_q;

        if (pop) begin
            a_out_d = a_dout;
            b_out_d = b_dout;
        end
        if (s_vld_q & s_rdy) s_vld_d = 1'b0;

        if (start) begin
            len_d  = {1'b0, max_cntr} + 9'd1;
            sgn_d  = sgn;
            acc_d  = '0;
            cnt_d  = '0;
            sat_d  = 1'b0;
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end else if (!stall) begin
            s1_v_d = pop;
            if (pop) begin
                s1_a_d = a_dout;
                s1_b_d = b_dout;
            end
            s2_v_d = s1_v_q;
            if (s1_v_q) prod_d = prod_full;
            if (done) begin
                s_out_d = acc_q;
                s_sat_d = sat_q;
                s_vld_d = 1'b1;
            end
            acc_d = acc_base;
            cnt_d = cnt_base;
            sat_d = sat_base;
            if (s2_v_q) begin
                acc_d = sum_c;
                cnt_d = cnt_base + 9'd1;
                sat_d = sat_base | (ovf & (SAT_EN != 0));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_v_q       <= 1'b0;
            s2_v_q       <= 1'b0;
            prod_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            sgn_q        <= 1'b0;
            sat_q        <= 1'b0;
            a_out_q      <= '0;
            b_out_q      <= '0;
            a_vld_q      <= 1'b0;
            b_vld_q      <= 1'b0;
            start_next_q <= 1'b0;
            s_out_q      <= '0;
            s_sat_q      <= 1'b0;
            s_vld_q      <= 1'b0;
        end else begin
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_v_q       <= s1_v_d;
            s2_v_q       <= s2_v_d;
            prod_q       <= prod_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            sgn_q        <= sgn_d;
            sat_q        <= sat_d;
            a_out_q      <= a_out_d;
            b_out_q      <= b_out_d;
            a_vld_q      <= a_vld_d;
            b_vld_q      <= b_vld_d;
            start_next_q <= start_next_d;
            s_out_q      <= s_out_d;
            s_sat_q      <= s_sat_d;
            s_vld_q      <= s_vld_d;
        end
    end

    assign a_out      = a_out_q;
    assign b_out      = b_out_q;
    assign a_vld      = a_vld_q;
    assign b_vld      = b_vld_q;
    assign start_next = start_next_q;
    assign s_out      = s_out_q;
    assign s_sat      = s_sat_q;
    assign s_vld      = s_vld_q;
endmodule

// File: tb/tb_pe_param.sv
// Directed bench for pe_param: three instances (AW=40 sat, AW=32 sat, AW=32 wrap)
// share all stimulus; monitors log forwarded operands and accepted results.

module tb_pe_param;
    logic        clk = 1'b0;
    logic        rst, a_we, b_we, sgn, start, hold, s_rdy;
    logic [15:0] a_in, b_in;
    logic [7:0]  max_cntr;

    logic        aff0, bff0, a_vld0, b_vld0, sn0, s_sat0, s_vld0;
    logic [15:0] a_out0, b_out0;
    logic [39:0] s_out0;
    logic        aff1, bff1, a_vld1, b_vld1, sn1, s_sat1, s_vld1;
    logic [15:0] a_out1, b_out1;
    logic [31:0] s_out1;
    logic        aff2, bff2, a_vld2, b_vld2, sn2, s_sat2, s_vld2;
    logic [15:0] a_out2, b_out2;
    logic [31:0] s_out2;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_av = 0;
    int svcnt = 0;
    logic [63:0] res_q[$], sat_q[$], res1_q[$], sat1_q[$], res2_q[$], sat2_q[$];
    logic [15:0] aq[$], bq[$];
    int svc_q[$];

    pe_param #(.DW(16), .AW(40), .FDEPTH(4), .SAT_EN(1)) u0 (
        .clk(clk), .rst(rst), .a_in(a_in), .a_we(a_we), .b_in(b_in), .b_we(b_we),
        .aff(aff0), .bff(bff0), .sgn(sgn), .start(start), .max_cntr(max_cntr),
        .hold(hold), .a_out(a_out0), .a_vld(a_vld0), .b_out(b_out0), .b_vld(b_vld0),
        .start_next(sn0), .s_out(s_out0), .s_sat(s_sat0), .s_vld(s_vld0), .s_rdy(s_rdy)
    );
    pe_param #(.DW(16), .AW(32), .FDEPTH(4), .SAT_EN(1)) u1 (
        .clk(clk), .rst(rst), .a_in(a_in), .a_we(a_we), .b_in(b_in), .b_we(b_we),
        .aff(aff1), .bff(bff1), .sgn(sgn), .start(start), .max_cntr(max_cntr),
        .hold(hold), .a_out(a_out1), .a_vld(a_vld1), .b_out(b_out1), .b_vld(b_vld1),
        .start_next(sn1), .s_out(s_out1), .s_sat(s_sat1), .s_vld(s_vld1), .s_rdy(s_rdy)
    );
    pe_param #(.DW(16), .AW(32), .FDEPTH(4), .SAT_EN(0)) u2 (
        .clk(clk), .rst(rst), .a_in(a_in), .a_we(a_we), .b_in(b_in), .b_we(b_we),
        .aff(aff2), .bff(bff2), .sgn(sgn), .start(start), .max_cntr(max_cntr),
        .hold(hold), .a_out(a_out2), .a_vld(a_vld2), .b_out(b_out2), .b_vld(b_vld2),
        .start_next(sn2), .s_out(s_out2), .s_sat(s_sat2), .s_vld(s_vld2), .s_rdy(s_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_vld0) begin
            aq.push_back(a_out0);
            last_av = cyc;
        end
        if (b_vld0) bq.push_back(b_out0);
        if (s_vld0) svcnt = svcnt + 1;
        if (s_vld0 && s_rdy) begin
            res_q.push_back(64'(s_out0));
            sat_q.push_back(64'(s_sat0));
            svc_q.push_back(cyc);
        end
        if (s_vld1 && s_rdy) begin
            res1_q.push_back(64'(s_out1));
            sat1_q.push_back(64'(s_sat1));
        end
        if (s_vld2 && s_rdy) begin
            res2_q.push_back(64'(s_out2));
            sat2_q.push_back(64'(s_sat2));
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_we = 1'b0; b_we = 1'b0; start = 1'b0; hold = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, 64'({aff0, bff0, a_vld0, b_vld0, sn0, s_sat0, s_vld0}), 64'd0);
        check({tag, "_a_out"}, 64'(a_out0), 64'd0);
        check({tag, "_b_out"}, 64'(b_out0), 64'd0);
        check({tag, "_s_out"}, 64'(s_out0), 64'd0);
    endtask

    task automatic do_start(input logic [7:0] mc, input logic s);
        max_cntr = mc; sgn = s; start = 1'b1;
        tick();
        check("start_next", 64'(sn0), 64'd1);
        start = 1'b0;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        a_in = a; b_in = b; a_we = 1'b1; b_we = 1'b1;
        tick();
        a_we = 1'b0; b_we = 1'b0;
    endtask

    task automatic pusha(input logic [15:0] a);
        a_in = a; a_we = 1'b1;
        tick();
        a_we = 1'b0;
    endtask

    task automatic pushb(input logic [15:0] b);
        b_in = b; b_we = 1'b1;
        tick();
        b_we = 1'b0;
    endtask

    task automatic wait_res(input int n, input string tag);
        for (int i = 0; i < 300 && res_q.size() < n; i++) tick();
        check(tag, 64'(res_q.size()), 64'(n));
    endtask

    int ra, ab, svb, aqs;

    initial begin
        a_in = '0; b_in = '0; sgn = 1'b0; max_cntr = '0; s_rdy = 1'b1;
        do_reset();
        check_zero("rst");

        // dot product 1*5+2*6+3*7+4*8, latency and forwarding
        ra = res_q.size(); ab = aq.size(); svb = svcnt;
        do_start(8'd3, 1'b0);
        for (int i = 0; i < 4; i++) push(16'(i + 1), 16'(i + 5));
        wait_res(ra + 1, "t1_cnt");
        repeat (3) tick();
        check("t1_sum", res_q[ra], 64'd70);
        check("t1_sat", sat_q[ra], 64'd0);
        check("t1_lat", 64'(svc_q[ra] - last_av), 64'd3);
        check("t1_vlen", 64'(svcnt - svb), 64'd1);
        check("t1_npop", 64'(aq.size() - ab), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_aseq", 64'(aq[ab + i]), 64'(i + 1));
            check("t1_bseq", 64'(bq[ab + i]), 64'(i + 5));
        end

        // signed -3*7 + -2*4, then same bit patterns unsigned
        ra = res_q.size();
        do_start(8'd1, 1'b1);
        push(16'hFFFD, 16'd7);
        push(16'hFFFE, 16'd4);
        wait_res(ra + 1, "t2_cnt");
        check("t2_signed", res_q[ra], 64'hFF_FFFF_FFE3);
        do_start(8'd1, 1'b0);
        push(16'hFFFD, 16'd7);
        push(16'hFFFE, 16'd4);
        wait_res(ra + 2, "t2_cnt_u");
        check("t2_unsigned", res_q[ra + 1], 64'h0_000A_FFE3);

        // 3 x (0x8000*0x8000) signed: AW=32 saturates / wraps, AW=40 fits
        do_reset();
        ra = res_q.size();
        do_start(8'd2, 1'b1);
        for (int i = 0; i < 3; i++) push(16'h8000, 16'h8000);
        wait_res(ra + 1, "t3_cnt");
        repeat (2) tick();
        check("t3_sat_val", res1_q[res1_q.size() - 1], 64'h7FFF_FFFF);
        check("t3_sat_bit", sat1_q[sat1_q.size() - 1], 64'd1);
        check("t3_wrap_val", res2_q[res2_q.size() - 1], 64'hC000_0000);
        check("t3_wrap_bit", sat2_q[sat2_q.size() - 1], 64'd0);
        check("t3_wide_val", res_q[ra], 64'hC000_0000);
        check("t3_wide_bit", sat_q[ra], 64'd0);

        // back-pressure: 2-term results, consumer stalled after the first
        do_reset();
        s_rdy = 1'b0;
        ra = res_q.size();
        do_start(8'd1, 1'b0);
        for (int i = 1; i <= 4; i++) push(16'(i), 16'(i));
        for (int i = 0; i < 50 && !s_vld0; i++) tick();
        check("t4_vld", 64'(s_vld0), 64'd1);
        aqs = aq.size();
        repeat (3) tick();
        check("t4_held_vld", 64'(s_vld0), 64'd1);
        check("t4_held_out", 64'(s_out0), 64'd5);
        for (int i = 5; i <= 8; i++) push(16'(i), 16'(i));
        check("t4_aff", 64'(aff0), 64'd1);
        check("t4_bff", 64'(bff0), 64'd1);
        check("t4_nopop", 64'(aq.size()), 64'(aqs));
        check("t4_still_out", 64'(s_out0), 64'd5);
        s_rdy = 1'b1;
        wait_res(ra + 4, "t4_cnt");
        check("t4_r1", res_q[ra], 64'd5);
        check("t4_r2", res_q[ra + 1], 64'd25);
        check("t4_r3", res_q[ra + 2], 64'd61);
        check("t4_r4", res_q[ra + 3], 64'd113);

        // hold: five A writes into a 4-deep FIFO, fifth dropped
        do_reset();
        hold = 1'b1;
        do_start(8'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            pusha(16'(10 + i));
            if (i == 2) check("t5_aff_pre", 64'(aff0), 64'd0);
            if (i >= 3) check("t5_aff", 64'(aff0), 64'd1);
        end
        for (int i = 0; i < 4; i++) pushb(16'd1);
        check("t5_hold_nopop", 64'(a_vld0), 64'd0);
        ab = aq.size(); ra = res_q.size();
        hold = 1'b0;
        wait_res(ra + 4, "t5_cnt");
        repeat (4) tick();
        check("t5_npop", 64'(aq.size() - ab), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("t5_aval", 64'(aq[ab + i]), 64'(10 + i));
            check("t5_res", res_q[ra + i], 64'(10 + i));
        end
        check("t5_aff_end", 64'(aff0), 64'd0);

        // reset after two of four terms discards the partial sum
        do_reset();
        do_start(8'd3, 1'b0);
        push(16'd1, 16'd1);
        push(16'd2, 16'd2);
        repeat (4) tick();
        do_reset();
        check_zero("t6_rst");
        ra = res_q.size();
        do_start(8'd0, 1'b0);
        push(16'd3, 16'd5);
        wait_res(ra + 1, "t6_cnt");
        check("t6_res", res_q[ra], 64'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
